// File: rtl/pwm_bank_pkg.sv
// Shared types for the PWM bank: counting mode, counter direction and
// the width helper for the duty channel-select port.
package pwm_bank_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // A single channel still needs a one-bit select port.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: shadow/active duty pair, compare against the shared
// counter, polarity inversion and the output register.
module pwm_channel
    import pwm_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             pol_i,
    output logic             pwm_o
);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;
    logic             raw;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        raw      = (cnt_i < active_q);
        if (we_i) begin
            shadow_d = wdata_i;
        end
        // A write landing on a load point goes straight through to active.
        if (load_i) begin
            active_d = we_i ? wdata_i : shadow_q;
        end
        pwm_d = en ? (raw ^ pol_i) : pol_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Bank of PWM channels sharing one up or up/down counter; period, mode
// and duties are double-buffered and swap in at period boundaries.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [WIDTH-1:0]    period,
    input  logic [CHANNELS-1:0] pol,
    input  logic                duty_we,
    input  logic [SEL_W-1:0]    duty_sel,
    input  logic [WIDTH-1:0]    duty_wdata,
    output logic [CHANNELS-1:0] pwm_o,
    output logic                period_end_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    pwm_dir_e         dir_q, dir_d;
    pwm_mode_e        mode_q, mode_d;
    logic             period_end_q, period_end_d;
    logic             center;
    logic             end_cycle;
    logic             load;

    always_comb begin
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        period_d     = period_q;
        mode_d       = mode_q;
        // Center counting needs P>=2; otherwise it degenerates to edge.
        center       = (mode_q == PWM_CENTER) && (period_q >= WIDTH'(2));
        end_cycle    = center ? ((dir_q == DIR_DOWN) && (cnt_q == WIDTH'(1)))
                              : (cnt_q == period_q);
        load         = !en || end_cycle;
        period_end_d = en && end_cycle;

        if (load) begin
            cnt_d    = '0;
            dir_d    = DIR_UP;
            period_d = period;
            mode_d   = pwm_mode_e'(mode);
        end else if (!center) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if ((dir_q == DIR_UP) && (cnt_q < period_q)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else begin
            cnt_d = cnt_q - WIDTH'(1);
            dir_d = DIR_DOWN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            period_q     <= '0;
            mode_q       <= PWM_EDGE;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            period_q     <= period_d;
            mode_q       <= mode_d;
            period_end_q <= period_end_d;
        end
    end

    assign period_end_o = period_end_q;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            pwm_channel #(
                .WIDTH(WIDTH)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .en     (en),
                .load_i (load),
                .we_i   (duty_we && (duty_sel == SEL_W'(gi))),
                .wdata_i(duty_wdata),
                .cnt_i  (cnt_q),
                .pol_i  (pol[gi]),
                .pwm_o  (pwm_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank (WIDTH=8, CHANNELS=4): edge, center,
// degenerate periods, double buffering, idle and asynchronous reset.
module tb_pwm_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] period;
    logic [3:0] pol;
    logic       duty_we;
    logic [1:0] duty_sel;
    logic [7:0] duty_wdata;
    logic [3:0] pwm_o;
    logic       period_end_o;

    int checks   = 0;
    int failures = 0;

    pwm_bank #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .period      (period),
        .pol         (pol),
        .duty_we     (duty_we),
        .duty_sel    (duty_sel),
        .duty_wdata  (duty_wdata),
        .pwm_o       (pwm_o),
        .period_end_o(period_end_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] data);
        duty_sel   = sel;
        duty_wdata = data;
        duty_we    = 1'b1;
        tick();
        duty_we    = 1'b0;
    endtask

    int         cseq [8];
    logic [7:0] d1;

    initial begin
        cseq = '{0, 1, 2, 3, 4, 3, 2, 1};
        rst = 1'b1; en = 1'b0; mode = 1'b0; period = 8'd9; pol = 4'b1000;
        duty_we = 1'b0; duty_sel = 2'd0; duty_wdata = 8'd0;

        // Reset state
        tick();
        chk("reset_pwm", {4'b0, pwm_o}, 8'h00);
        chk("reset_pe", {7'b0, period_end_o}, 8'h00);
        rst = 1'b0;

        // Idle loads: write-through of all duties, pwm follows pol
        wr(2'd0, 8'd3);
        wr(2'd1, 8'd0);
        wr(2'd2, 8'd10);
        wr(2'd3, 8'd0);
        chk("idle_pol", {4'b0, pwm_o}, 8'h08);
        chk("idle_pe", {7'b0, period_end_o}, 8'h00);

        // Edge P=9: ch0 3/10, ch1 const 0, ch2 const 1, ch3 inverted const 1
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            $display("edge k=%0d pwm=%b pe=%b", k, pwm_o, period_end_o);
            chk("edge_pwm", {4'b0, pwm_o}, {4'b0, 3'b110, (k % 10) < 3});
            chk("edge_pe", {7'b0, period_end_o}, {7'b0, (k % 10) == 9});
        end

        // en drop: pwm_o = pol next cycle
        en = 1'b0;
        tick();
        chk("endrop_pwm", {4'b0, pwm_o}, 8'h08);
        chk("endrop_pe", {7'b0, period_end_o}, 8'h00);

        // Double buffering on ch1: 7 written mid-period, 5 at the end cycle
        wr(2'd1, 8'd2);
        en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 4) begin
                duty_sel = 2'd1; duty_wdata = 8'd7; duty_we = 1'b1;
            end else if (k == 19) begin
                duty_sel = 2'd1; duty_wdata = 8'd5; duty_we = 1'b1;
            end
            tick();
            duty_we = 1'b0;
            d1 = (k < 10) ? 8'd2 : (k < 20) ? 8'd7 : 8'd5;
            $display("dbuf k=%0d pwm=%b pe=%b", k, pwm_o, period_end_o);
            chk("dbuf_pwm", {4'b0, pwm_o},
                {4'b0, 2'b11, (k % 10) < int'(d1), (k % 10) < 3});
        end

        // Center P=4, duty0=2: high at cnt 0,1 and trailing 1
        en = 1'b0; mode = 1'b1; period = 8'd4;
        wr(2'd0, 8'd2);
        en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            $display("center k=%0d pwm=%b pe=%b", k, pwm_o, period_end_o);
            chk("center_pwm", {4'b0, pwm_o}, {4'b0, 3'b111, cseq[k % 8] < 2});
            chk("center_pe", {7'b0, period_end_o}, {7'b0, (k % 8) == 7});
        end

        // Center with P=1 behaves as edge: cnt 0,1,0,1
        en = 1'b0; period = 8'd1;
        wr(2'd0, 8'd1);
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            $display("p1 k=%0d pwm=%b pe=%b", k, pwm_o, period_end_o);
            chk("p1_pwm", {4'b0, pwm_o}, {4'b0, 3'b111, (k % 2) == 0});
            chk("p1_pe", {7'b0, period_end_o}, {7'b0, (k % 2) == 1});
        end

        // P=0: cnt stuck at 0, every cycle ends a period
        en = 1'b0; period = 8'd0;
        tick();
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            $display("p0 k=%0d pwm=%b pe=%b", k, pwm_o, period_end_o);
            chk("p0_pwm", {4'b0, pwm_o}, 8'h0F);
            chk("p0_pe", {7'b0, period_end_o}, 8'h01);
        end

        // Edge P=9 again, then asynchronous reset mid-period
        en = 1'b0; mode = 1'b0; period = 8'd9;
        tick();
        en = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("prereset_pwm", {4'b0, pwm_o}, 8'h0E);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pwm", {4'b0, pwm_o}, 8'h00);
        chk("async_rst_pe", {7'b0, period_end_o}, 8'h00);
        tick();
        rst = 1'b0; en = 1'b0; pol = 4'b0000;
        tick();
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            $display("postrst k=%0d pwm=%b pe=%b", k, pwm_o, period_end_o);
            chk("cleared_duty_pwm", {4'b0, pwm_o}, 8'h00);
        end

        // en dropped with pol=0101
        pol = 4'b0101; en = 1'b0;
        tick();
        chk("idle_0101_pwm", {4'b0, pwm_o}, 8'h05);
        chk("idle_0101_pe", {7'b0, period_end_o}, 8'h00);

        // Restart counts from cnt 0: duty0=1 gives one high cycle
        pol = 4'b0000;
        wr(2'd0, 8'd1);
        en = 1'b1;
        tick();
        chk("restart_cnt0", {4'b0, pwm_o}, 8'h01);
        tick();
        chk("restart_cnt1", {4'b0, pwm_o}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
